// File: rtl/csb_target_router.sv
// csb_target_router: routes one CSB transaction at a time to NUM_CH targets, with unmapped-address errors, response timeout and stray-response status
module csb_target_router #(
  parameter int NUM_CH = 16,
  parameter int CH_W = 5,
  parameter int ADDR_W = 16,
  parameter int CH_SEL_LSB = 10,
  parameter logic [NUM_CH-1:0] CH_EN = {NUM_CH{1'b1}},
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   csb2nvdla_valid,
  output logic                   csb2nvdla_ready,
  input  logic [ADDR_W-1:0]      csb2nvdla_addr,
  input  logic [31:0]            csb2nvdla_wdat,
  input  logic                   csb2nvdla_write,
  input  logic                   csb2nvdla_nposted,
  output logic                   nvdla2csb_valid,
  output logic                   nvdla2csb_wr_complete,
  output logic [31:0]            nvdla2csb_data,
  output logic                   nvdla2csb_err,
  output logic [NUM_CH-1:0]      csb2tgt_req_pvld,
  input  logic [NUM_CH-1:0]      csb2tgt_req_prdy,
  output logic [ADDR_W+33:0]     csb2tgt_req_pd,
  input  logic [NUM_CH-1:0]      tgt2csb_resp_valid,
  input  logic [NUM_CH*34-1:0]   tgt2csb_resp_pd,
  input  logic                   err_clr,
  output logic                   stat_stray,
  output logic                   stat_timeout
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} st_t;
  st_t st, nst;
  logic [ADDR_W-1:0] a_q;
  logic [31:0] wd_q, rd_q;
  logic wr_q, np_q, re_q;
  logic [CH_W-1:0] idx_q, d_idx;
  logic [15:0] cnt;
  logic [2**CH_W-1:0] en_ext;
  logic [NUM_CH-1:0] sel_oh;
  logic [33:0] sel_pd;
  logic mapped, acc, sel_vld, expire, stray, tout, unused_is_wr;
  assign en_ext = (2**CH_W)'(CH_EN);
  assign d_idx = csb2nvdla_addr[CH_SEL_LSB +: CH_W];
  assign mapped = en_ext[d_idx];
  assign acc = csb2nvdla_valid && st == IDLE;
  assign sel_oh = NUM_CH'(1) << idx_q;
  assign sel_vld = |(tgt2csb_resp_valid & sel_oh);
  assign expire = cnt == 16'(TIMEOUT_CYC - 1);
  assign stray = |(tgt2csb_resp_valid & ~((st == WAIT) ? sel_oh : '0));
  assign tout = st == WAIT && expire && !sel_vld;
  assign unused_is_wr = sel_pd[32];
  always_comb begin
    sel_pd = '0;
    for (int i = 0; i < NUM_CH; i++) sel_pd = (idx_q == CH_W'(i)) ? tgt2csb_resp_pd[34*i +: 34] : sel_pd;
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      st <= IDLE;
      a_q <= '0;
      wd_q <= '0;
      wr_q <= 1'b0;
      np_q <= 1'b0;
      idx_q <= '0;
      cnt <= '0;
      rd_q <= '0;
      re_q <= 1'b0;
      stat_stray <= 1'b0;
      stat_timeout <= 1'b0;
    end else begin
      st <= nst;
      cnt <= (st == WAIT) ? cnt + 16'd1 : '0;
      if (acc) begin
        a_q <= csb2nvdla_addr;
        wd_q <= csb2nvdla_wdat;
        wr_q <= csb2nvdla_write;
        np_q <= csb2nvdla_nposted;
        idx_q <= d_idx;
        rd_q <= '0;
        re_q <= 1'b1;
      end
      if (st == WAIT) begin
        rd_q <= sel_vld ? sel_pd[31:0] : '0;
        re_q <= sel_vld ? sel_pd[33] : 1'b1;
      end
      stat_stray <= stray | (stat_stray & ~err_clr);
      stat_timeout <= tout | (stat_timeout & ~err_clr);
    end
  end
  always_comb begin
    nst = st;
    case (st)
      IDLE: nst = !acc ? IDLE : mapped ? REQ : (csb2nvdla_write && !csb2nvdla_nposted) ? IDLE : RESP;
      REQ:  nst = !(|(csb2tgt_req_prdy & sel_oh)) ? REQ : (wr_q && !np_q) ? IDLE : WAIT;
      WAIT: nst = (sel_vld || expire) ? RESP : WAIT;
      default: nst = IDLE;
    endcase
  end
  always_comb begin
    csb2nvdla_ready = st == IDLE;
    csb2tgt_req_pvld = (st == REQ) ? sel_oh : '0;
    csb2tgt_req_pd = {np_q, wr_q, wd_q, a_q};
    nvdla2csb_valid = st == RESP && !wr_q;
    nvdla2csb_wr_complete = st == RESP && wr_q;
    nvdla2csb_data = (st == RESP && !wr_q) ? rd_q : '0;
    nvdla2csb_err = st == RESP && re_q;
  end
endmodule

// File: tb/tb_csb_target_router.sv
// tb_csb_target_router: randomized scoreboard bench for csb_target_router with directed corner cases
module tb_csb_target_router;
  localparam int NCH = 16;
  localparam int TO = 16;
  localparam logic [15:0] EN = 16'hFDFF;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic csb2nvdla_valid = 1'b0, csb2nvdla_ready;
  logic [15:0] csb2nvdla_addr = '0;
  logic [31:0] csb2nvdla_wdat = '0;
  logic csb2nvdla_write = 1'b0, csb2nvdla_nposted = 1'b0;
  logic nvdla2csb_valid, nvdla2csb_wr_complete, nvdla2csb_err;
  logic [31:0] nvdla2csb_data;
  logic [NCH-1:0] csb2tgt_req_pvld;
  logic [NCH-1:0] csb2tgt_req_prdy = '0;
  logic [49:0] csb2tgt_req_pd;
  logic [NCH-1:0] tgt2csb_resp_valid = '0;
  logic [NCH*34-1:0] tgt2csb_resp_pd = '0;
  logic err_clr = 1'b0;
  logic stat_stray, stat_timeout;
  csb_target_router #(.NUM_CH(NCH), .CH_W(5), .ADDR_W(16), .CH_SEL_LSB(10), .CH_EN(EN), .TIMEOUT_CYC(TO)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rstn(rstn),
    .csb2nvdla_valid(csb2nvdla_valid),
    .csb2nvdla_ready(csb2nvdla_ready),
    .csb2nvdla_addr(csb2nvdla_addr),
    .csb2nvdla_wdat(csb2nvdla_wdat),
    .csb2nvdla_write(csb2nvdla_write),
    .csb2nvdla_nposted(csb2nvdla_nposted),
    .nvdla2csb_valid(nvdla2csb_valid),
    .nvdla2csb_wr_complete(nvdla2csb_wr_complete),
    .nvdla2csb_data(nvdla2csb_data),
    .nvdla2csb_err(nvdla2csb_err),
    .csb2tgt_req_pvld(csb2tgt_req_pvld),
    .csb2tgt_req_prdy(csb2tgt_req_prdy),
    .csb2tgt_req_pd(csb2tgt_req_pd),
    .tgt2csb_resp_valid(tgt2csb_resp_valid),
    .tgt2csb_resp_pd(tgt2csb_resp_pd),
    .err_clr(err_clr),
    .stat_stray(stat_stray),
    .stat_timeout(stat_timeout)
  );
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic [33:0] exp_q[$];
  bit exp_stray = 1'b0;
  bit exp_to = 1'b0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready;
    int n = 0;
    while (!csb2nvdla_ready && n < 100) begin
      step;
      n++;
    end
    if (!csb2nvdla_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_wait: ready=0 expected 1 after %0d cycles", n);
    end
  endtask
  always @(negedge clk) begin
    if (rstn && (nvdla2csb_valid || nvdla2csb_wr_complete)) begin
      chk("pulse_exclusive", nvdla2csb_valid & nvdla2csb_wr_complete, 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got wr=%0b err=%0b data=%0h expected no pulse", nvdla2csb_wr_complete, nvdla2csb_err, nvdla2csb_data);
      end else chk("resp", {nvdla2csb_wr_complete, nvdla2csb_err, nvdla2csb_data}, exp_q.pop_front());
    end
  end
  task automatic txn(input logic [15:0] a, input logic [31:0] wd, input logic w, input logic np,
                     input int pdly, input int rdly, input int sj, input logic [31:0] rd, input logic re);
    int ch = int'(a[14:10]);
    bit mapped = (ch < NCH) && EN[ch[3:0]];
    bit posted = w && !np;
    bit tmo = mapped && !posted && rdly >= TO;
    logic [NCH-1:0] rv;
    wait_ready();
    if (!posted) exp_q.push_back((!mapped || tmo) ? {w, 1'b1, 32'h0} : {w, re, w ? 32'h0 : rd});
    if (tmo) exp_to = 1'b1;
    csb2nvdla_valid = 1'b1;
    csb2nvdla_addr = a;
    csb2nvdla_wdat = wd;
    csb2nvdla_write = w;
    csb2nvdla_nposted = np;
    step;
    csb2nvdla_valid = 1'b0;
    if (!mapped) chk("unmapped_pvld", csb2tgt_req_pvld, 0);
    else begin
      for (int k = 0; k <= pdly; k++) begin
        chk("pvld", csb2tgt_req_pvld, 16'(1) << ch);
        chk("pd", csb2tgt_req_pd, {np, w, wd, a});
        if (k == pdly) csb2tgt_req_prdy[ch] = 1'b1;
        step;
      end
      csb2tgt_req_prdy = '0;
      if (!posted) begin
        for (int k = 0; k < TO && k <= rdly; k++) begin
          rv = '0;
          if (k == rdly) begin
            rv[ch] = 1'b1;
            tgt2csb_resp_pd[34*ch +: 34] = {re, 1'($urandom), rd};
          end
          if (sj >= 0 && k == 0) begin
            rv[sj] = 1'b1;
            exp_stray = 1'b1;
          end
          tgt2csb_resp_valid = rv;
          step;
        end
        tgt2csb_resp_valid = '0;
      end
    end
    if (!posted) begin
      chk("pulse_kind", {nvdla2csb_valid, nvdla2csb_wr_complete}, {!w, w});
      step;
    end
    chk("ready_back", csb2nvdla_ready, 1);
    chk("stat_stray", stat_stray, exp_stray);
    chk("stat_timeout", stat_timeout, exp_to);
  endtask
  task automatic clr;
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    exp_stray = 1'b0;
    exp_to = 1'b0;
    chk("clr_stray", stat_stray, exp_stray);
    chk("clr_timeout", stat_timeout, exp_to);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int c, sj, rdly;
    repeat (2) step;
    chk("rst_ready", csb2nvdla_ready, 1);
    chk("rst_pvld", csb2tgt_req_pvld, 0);
    chk("rst_pd", csb2tgt_req_pd, 0);
    chk("rst_pulse", {nvdla2csb_valid, nvdla2csb_wr_complete, nvdla2csb_err, nvdla2csb_data}, 0);
    chk("rst_stat", {stat_stray, stat_timeout}, 0);
    @(negedge clk);
    rstn = 1'b1;
    step;
    txn(16'h0C04, 32'h0, 1'b0, 1'b0, 0, 3, -1, 32'h12345678, 1'b0);
    txn(16'h1400, 32'hA5A5A5A5, 1'b1, 1'b0, 3, 0, -1, 32'h0, 1'b0);
    txn(16'h2400, 32'h11111111, 1'b1, 1'b1, 0, 0, -1, 32'h0, 1'b0);
    txn(16'hFC00, 32'h0, 1'b0, 1'b0, 0, 0, -1, 32'h0, 1'b0);
    txn(16'h0010, 32'h0, 1'b0, 1'b0, 0, 16, -1, 32'h0, 1'b0);
    tgt2csb_resp_valid[0] = 1'b1;
    step;
    tgt2csb_resp_valid = '0;
    exp_stray = 1'b1;
    chk("late_stray", stat_stray, exp_stray);
    chk("late_timeout", stat_timeout, exp_to);
    clr();
    txn(16'h0800, 32'h0, 1'b0, 1'b0, 0, 15, 7, 32'hCAFEF00D, 1'b0);
    txn(16'h0C00, 32'h5, 1'b1, 1'b1, 1, 2, -1, 32'hFFFF, 1'b1);
    clr();
    for (int n = 0; n < 150; n++) begin
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
      sj = ($urandom_range(0, 7) == 0) ? int'((c + 1 + int'($urandom_range(0, 14))) % 16) : -1;
      rdly = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 15));
      txn({1'($urandom), 5'(c), 10'($urandom)}, $urandom, 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 3)), rdly, sj, $urandom, 1'($urandom));
      if ($urandom_range(0, 9) == 0) clr();
    end
    wait_ready();
    csb2nvdla_valid = 1'b1;
    csb2nvdla_addr = 16'h0800;
    csb2nvdla_write = 1'b0;
    step;
    csb2nvdla_valid = 1'b0;
    csb2tgt_req_prdy[2] = 1'b1;
    step;
    csb2tgt_req_prdy = '0;
    repeat (2) step;
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", csb2nvdla_ready, 1);
    chk("mid_rst_pvld", csb2tgt_req_pvld, 0);
    chk("mid_rst_pulse", {nvdla2csb_valid, nvdla2csb_wr_complete, nvdla2csb_err, nvdla2csb_data}, 0);
    chk("mid_rst_stat", {stat_stray, stat_timeout}, 0);
    @(negedge clk);
    rstn = 1'b1;
    exp_stray = 1'b0;
    exp_to = 1'b0;
    step;
    tgt2csb_resp_pd[34*2 +: 34] = {1'b0, 1'b0, 32'h600DF00D};
    tgt2csb_resp_valid[2] = 1'b1;
    step;
    tgt2csb_resp_valid = '0;
    exp_stray = 1'b1;
    chk("post_rst_stray", stat_stray, exp_stray);
    chk("post_rst_timeout", stat_timeout, exp_to);
    chk("post_rst_ready", csb2nvdla_ready, 1);
    repeat (3) step;
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
